// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg -- shared definitions for the PS/2 keyboard decoder.
//   frame_state_e : frame receive FSM states
//   KEY_*         : bit positions inside the ps2_key event word
//   BYTE_*        : special scan-code bytes recognised by the decoder
//   is_ignored()  : bytes that are dropped without any effect on state
// ---------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_e;

   localparam int KEY_TOGGLE   = 10;
   localparam int KEY_PRESSED  = 9;
   localparam int KEY_EXT      = 8;
   localparam int KEY_CODE_MSB = 7;

   localparam logic [7:0] BYTE_EXT    = 8'hE0;
   localparam logic [7:0] BYTE_REL    = 8'hF0;
   localparam logic [7:0] BYTE_PAUSE  = 8'hE1;
   localparam logic [7:0] BYTE_ACK    = 8'hFA;
   localparam logic [7:0] BYTE_BAT    = 8'hAA;
   localparam logic [7:0] BYTE_ECHO   = 8'hEE;
   localparam logic [7:0] BYTE_RESEND = 8'hFE;

   // Protocol/housekeeping bytes that never form a key event.
   function automatic logic is_ignored(input logic [7:0] b);
      return (b == BYTE_PAUSE) || (b == BYTE_ACK) || (b == BYTE_BAT) ||
             (b == BYTE_ECHO) || (b == BYTE_RESEND) || (b == 8'h00) ||
             (b == 8'hFF);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter -- 2-FF synchronizer followed by a persistence filter for
// one PS/2 line. The output follows the synchronized input only after
// FILT_LEN consecutive samples that differ from the current output.
//   clk_sys  in  system clock
//   RESET_N  in  async active-low reset (sync + output reset to 1, idle bus)
//   line_i   in  raw asynchronous PS/2 line
//   line_o   out filtered line level
// ---------------------------------------------------------------------------
module ps2_line_filter #(
   parameter int FILT_LEN = 8
) (
   input  logic clk_sys,
   input  logic RESET_N,
   input  logic line_i,
   output logic line_o
);

   localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

   logic [1:0]    sync_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q holds how many consecutive samples so far disagree with the
   // output; the FILT_LEN-th disagreeing sample flips the output.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == LAST) filt_d = sync_q[1];
         else               cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q <= 2'b11;
         filt_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], line_i};
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign line_o = filt_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder -- PS/2 keyboard receiver and scan-code event decoder.
//   clk_sys   in  system clock (only clock)
//   RESET_N   in  async active-low reset
//   ps2_clk   in  raw PS/2 clock
//   ps2_data  in  raw PS/2 data
//   ps2_key   out {toggle, pressed, extended, code}; toggle flips per event
//   err       out one-cycle pulse on framing/parity/stop error or timeout
// ---------------------------------------------------------------------------
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FILT_LEN = 8,
   parameter int TIMEOUT  = 20000
) (
   input  logic        clk_sys,
   input  logic        RESET_N,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic clk_f, data_f, clk_prev_q, fall;

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
      .clk_sys(clk_sys), .RESET_N(RESET_N), .line_i(ps2_clk),  .line_o(clk_f));
   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
      .clk_sys(clk_sys), .RESET_N(RESET_N), .line_i(ps2_data), .line_o(data_f));

   assign fall = clk_prev_q & ~clk_f;

   frame_state_e state_q, state_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          ext_q, ext_d, rel_q, rel_d;
   logic [10:0]   key_q, key_d;
   logic          err_d, err_q;
   logic [TW-1:0] tmo_q, tmo_d;

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      ext_d   = ext_q;
      rel_d   = rel_q;
      key_d   = key_q;
      err_d   = 1'b0;
      tmo_d   = '0;

      if (fall)                   tmo_d = '0;
      else if (state_q != ST_IDLE) tmo_d = tmo_q + 1'b1;

      if (state_q != ST_IDLE && !fall && tmo_q == TW'(TIMEOUT - 1)) begin
         err_d   = 1'b1;
         state_d = ST_IDLE;
         tmo_d   = '0;
      end else if (fall) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!data_f) begin
                  state_d = ST_DATA;
                  bit_d   = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_DATA: begin
               shift_d = {data_f, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: begin
               par_d   = data_f;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               // Parity is judged here rather than on the parity edge so the
               // stop-bit edge is consumed and cannot look like a bad start.
               state_d = ST_IDLE;
               if (!data_f || !(^{shift_q, par_q})) begin
                  err_d = 1'b1;
               end else if (shift_q == BYTE_EXT) begin
                  ext_d = 1'b1;
               end else if (shift_q == BYTE_REL) begin
                  rel_d = 1'b1;
               end else if (!is_ignored(shift_q)) begin
                  key_d[KEY_TOGGLE]       = ~key_q[KEY_TOGGLE];
                  key_d[KEY_PRESSED]      = ~rel_q;
                  key_d[KEY_EXT]          = ext_q;
                  key_d[KEY_CODE_MSB:0]   = shift_q;
                  ext_d = 1'b0;
                  rel_d = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (err_d) begin
         ext_d = 1'b0;
         rel_d = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         clk_prev_q <= 1'b1;
         state_q    <= ST_IDLE;
         bit_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         key_q      <= '0;
         err_q      <= 1'b0;
         tmo_q      <= '0;
      end else begin
         clk_prev_q <= clk_f;
         state_q    <= state_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         key_q      <= key_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
      end
   end

   assign ps2_key = key_q;
   assign err     = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder -- directed bench with an expected-event queue.
// Expected ps2_key values are queued before each frame is sent; a monitor
// pops one per observed ps2_key change and also checks event/err timing.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

   localparam int F   = 4;        // filter length
   localparam int T   = 300;      // timeout in clk_sys cycles
   localparam int H   = 20;       // PS/2 clock half period in clk_sys cycles
   localparam int LAT = F + 3;    // raw fall -> registered result (2 sync + F filter + 1)

   logic        clk_sys = 1'b0;
   logic        RESET_N = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        err;

   int checks = 0, errors = 0;
   int cyc = 0, last_fall = 0;
   int err_seen = 0, err_exp = 0;
   bit tmo_mode = 1'b0;
   logic [10:0] exp_q[$];
   logic [10:0] last_key = 11'h000;
   logic [10:0] exp_k;
   logic        err_prev = 1'b0;

   ps2_key_decoder #(.FILT_LEN(F), .TIMEOUT(T)) dut (
      .clk_sys(clk_sys), .RESET_N(RESET_N), .ps2_clk(ps2_clk),
      .ps2_data(ps2_data), .ps2_key(ps2_key), .err(err));

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // Monitor: every ps2_key change must match the next queued value and land
   // exactly LAT cycles after the stop-bit fall; err must be single-cycle.
   always @(negedge clk_sys) begin
      if (!RESET_N) begin
         last_key = 11'h000;
         err_prev = 1'b0;
      end else begin
         if (ps2_key !== last_key) begin
            checks++;
            assert (exp_q.size() != 0) else begin
               errors++; $error("FAIL key_unexpected observed=%h required=no_update", ps2_key);
            end
            if (exp_q.size() != 0) begin
               exp_k = exp_q.pop_front();
               checks++;
               assert (ps2_key === exp_k) else begin
                  errors++; $error("FAIL key_value observed=%h required=%h", ps2_key, exp_k);
               end
            end
            checks++;
            assert (cyc == last_fall + LAT) else begin
               errors++; $error("FAIL key_latency observed=%0d required=%0d", cyc - last_fall, LAT);
            end
            checks++;
            assert (err === 1'b0) else begin
               errors++; $error("FAIL key_with_err observed=%b required=0", err);
            end
            last_key = ps2_key;
         end
         if (err === 1'b1) begin
            err_seen++;
            checks++;
            assert (err_prev === 1'b0) else begin
               errors++; $error("FAIL err_width observed=multi_cycle required=1");
            end
            if (err_prev === 1'b0) begin
               checks++;
               assert (cyc == last_fall + LAT + (tmo_mode ? T : 0)) else begin
                  errors++; $error("FAIL err_latency observed=%0d required=%0d",
                                   cyc - last_fall, LAT + (tmo_mode ? T : 0));
               end
            end
         end
         err_prev = err;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      ps2_data = b;
      if (glitch) begin
         tick(5);
         ps2_clk = 1'b0;
         tick(F - 1);
         ps2_clk = 1'b1;
         tick(H - 5 - (F - 1));
      end else begin
         tick(H);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      tick(H);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input bit glitch);
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
      send_bit((~^b) ^ bad_par, glitch);
      send_bit(~bad_stop, glitch);
      ps2_data = 1'b1;
      tick(3 * H);
   endtask

   task automatic chk(input string tag);
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++; $error("FAIL %s_pending observed=%0d required=0", tag, exp_q.size());
      end
      checks++;
      assert (err_seen == err_exp) else begin
         errors++; $error("FAIL %s_errcount observed=%0d required=%0d", tag, err_seen, err_exp);
      end
   endtask

   initial begin
      tick(5);
      checks++;
      assert (ps2_key === 11'h000) else begin
         errors++; $error("FAIL reset_key observed=%h required=000", ps2_key);
      end
      checks++;
      assert (err === 1'b0) else begin
         errors++; $error("FAIL reset_err observed=%b required=0", err);
      end
      RESET_N = 1'b1;
      tick(10);
      chk("reset_release");

      exp_q.push_back(11'h61C); send_frame(8'h1C, 0, 0, 0); chk("make_1C");

      send_frame(8'hF0, 0, 0, 0);
      exp_q.push_back(11'h01C); send_frame(8'h1C, 0, 0, 0); chk("break_1C");

      send_frame(8'hE0, 0, 0, 0);
      exp_q.push_back(11'h775); send_frame(8'h75, 0, 0, 0); chk("ext_75");

      err_exp++; send_frame(8'h1C, 1, 0, 0); chk("bad_parity");

      send_frame(8'hF0, 0, 0, 0);
      err_exp++; send_frame(8'h1C, 1, 0, 0);
      exp_q.push_back(11'h21C); send_frame(8'h1C, 0, 0, 0); chk("flags_cleared");

      err_exp++; send_frame(8'h1C, 0, 1, 0); chk("bad_stop");

      send_frame(8'hF0, 0, 0, 0);
      send_frame(8'hAA, 0, 0, 0);
      send_frame(8'hFA, 0, 0, 0);
      exp_q.push_back(11'h41C); send_frame(8'h1C, 0, 0, 0); chk("ignored_bytes");

      // Partial frame after an E0 prefix: timeout must also drop the prefix.
      send_frame(8'hE0, 0, 0, 0);
      tmo_mode = 1'b1;
      err_exp++;
      send_bit(1'b0, 0);
      for (int i = 0; i < 4; i++) send_bit(i[0], 0);
      ps2_data = 1'b1;
      tick(T + LAT + 20);
      tmo_mode = 1'b0;
      chk("timeout");
      exp_q.push_back(11'h229); send_frame(8'h29, 0, 0, 0); chk("after_timeout");

      for (int i = 0; i < 3; i++) begin
         ps2_clk = 1'b0;
         tick(F - 1);
         ps2_clk = 1'b1;
         tick(H);
      end
      chk("idle_glitch");
      exp_q.push_back(11'h61C); send_frame(8'h1C, 0, 0, 1); chk("glitch_frame");

      // Reset in the middle of a frame (clock line held low at assertion).
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b0, 0);
      ps2_data = 1'b1;
      tick(H);
      ps2_clk = 1'b0;
      tick(2);
      RESET_N = 1'b0;
      tick(3);
      checks++;
      assert (ps2_key === 11'h000) else begin
         errors++; $error("FAIL midreset_key observed=%h required=000", ps2_key);
      end
      checks++;
      assert (err === 1'b0) else begin
         errors++; $error("FAIL midreset_err observed=%b required=0", err);
      end
      ps2_clk = 1'b1;
      tick(3);
      RESET_N = 1'b1;
      tick(20);
      exp_q.push_back(11'h61C); send_frame(8'h1C, 0, 0, 0); chk("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8: consecutive equal clk_sys samples required to accept a PS/2 line level change.
REQ-002 SHALL have parameter TIMEOUT, default 20000: clk_sys cycles without a filtered ps2_clk falling edge before an open frame aborts.
REQ-003 SHALL have port clk_sys  input  1  system clock; single clock domain.
REQ-004 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk_sys.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk_sys.
REQ-007 SHALL have port ps2_key  output  11  key event: [10] toggle, [9] pressed, [8] extended, [7:0] scan code.
REQ-008 SHALL have port err  output  1  one-cycle pulse on a frame error or timeout.

Function
REQ-009 SHALL pass each PS/2 line through a 2-FF synchronizer, then a filter whose output changes only after FILT_LEN consecutive equal synchronized samples.
REQ-010 SHALL sample filtered ps2_data on each filtered ps2_clk falling edge (1->0).
REQ-011 SHALL run frame FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, one edge per step.
REQ-012 SHALL, in IDLE, enter DATA only when the sampled start bit is 0; a sampled 1 pulses err and stays IDLE.
REQ-013 SHALL require odd parity over data plus parity bit; on mismatch, discard the byte, pulse err, return to IDLE.
REQ-014 SHALL require stop bit 1; a stop bit of 0 discards the byte, pulses err, returns to IDLE.
REQ-015 SHALL, outside IDLE, count clk_sys cycles since the last falling edge; on reaching TIMEOUT, pulse err, return to IDLE, discard partial data.
REQ-016 SHALL clear the pending extended and release flags on every err pulse.
REQ-017 SHALL, on a valid byte 0xE0, set the extended flag and emit no event.
REQ-018 SHALL, on a valid byte 0xF0, set the release flag and emit no event.
REQ-019 SHALL discard bytes 0xE1, 0xFA, 0xAA, 0xEE, 0xFE, 0x00 and 0xFF without altering flags or emitting an event.
REQ-020 SHALL, on any other valid byte, update ps2_key to {~ps2_key[10], ~release, extended, byte}, then clear both flags.
REQ-021 SHALL update ps2_key exactly 1 clk_sys cycle after the stop-bit sampling cycle, and change it at no other time.
REQ-022 SHALL hold ps2_key stable between events; consumers detect events by ps2_key[10] changing.
REQ-023 SHALL produce err as exactly one clk_sys cycle high per error, never in the same cycle as a ps2_key update.

Reset
REQ-024 SHALL, while RESET_N=0, force ps2_key=11'h000, err=0, FSM=IDLE, flags=0, timeout counter=0.
REQ-025 SHALL initialize synchronizers and filter outputs to 1 (idle-high bus), so no falling edge is detected at reset release.
REQ-026 SHALL, on reset assertion mid-frame, abandon the frame; the first full frame after release decodes normally.

Structure
REQ-027 SHALL place the frame-state enum, ps2_key field bit positions and special-byte constants (E0, F0, E1, FA, AA, EE, FE) in shared package ps2_pkg.
REQ-028 SHALL implement synchronizer plus filter as sub-module ps2_line_filter, instantiated once per PS/2 line.
REQ-029 SHALL contain no latches and no clock other than clk_sys.

Verification
REQ-030 SHALL cover: after reset, frame 0x1C with parity 0 -> ps2_key=11'h61C one cycle after stop, err stays 0.
REQ-031 SHALL cover: then frames F0, 1C -> one update only, ps2_key=11'h01C.
REQ-032 SHALL cover: then frames E0, 75 -> ps2_key=11'h775.
REQ-033 SHALL cover: frame 0x1C with parity 1 -> single-cycle err, ps2_key unchanged; a following F0 prefix is not inherited by the next byte.
REQ-034 SHALL cover: start plus 4 data bits, then idle -> err exactly TIMEOUT cycles after the last edge; a following frame 0x29 -> ps2_key[7:0]=0x29, [9]=1.
REQ-035 SHALL cover: glitches of FILT_LEN-1 cycles on ps2_clk -> no bit sampled; RESET_N pulsed mid-frame -> ps2_key=11'h000, next frame decodes.
